// File: rtl/gamepad_event_gen_if.sv
// Event delivery channel between gamepad_event_gen and its consumer.
//   evt_valid  : head of the event FIFO holds an event
//   evt_ready  : consumer accepts the head when evt_valid & evt_ready
//   evt_code   : button index of the head event
//   evt_repeat : head event is an auto-repeat (0 = first press)
// master = event producer, slave = event consumer.
interface gamepad_event_gen_if;
   logic       evt_valid;
   logic       evt_ready;
   logic [3:0] evt_code;
   logic       evt_repeat;

   modport master (output evt_valid, output evt_code, output evt_repeat, input evt_ready);
   modport slave  (input evt_valid, input evt_code, input evt_repeat, output evt_ready);
endinterface

// File: rtl/gamepad_event_gen.sv
// Turns the decoded gamepad level vector into a queued stream of press and
// auto-repeat events. Debounce and repeat timing advance only on frame_tick_i.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   btn_in_i       : button levels, active-high, synchronous to clk
//   present_i      : gamepad present; when low, all per-button state clears
//   frame_tick_i   : one-cycle sampling strobe per frame
//   btn_held_o     : debounced stable levels
//   evt_merged_o   : sticky flag, an event merged into an already-pending one
//   evt_if         : valid/ready event channel (show-ahead FIFO head)
module gamepad_event_gen #(
   parameter int          NUM_BTN        = 12,
   parameter logic [11:0] REPEAT_MASK    = 12'h0F0,
   parameter int          DEBOUNCE_TICKS = 2,
   parameter int          REPEAT_DELAY   = 20,
   parameter int          REPEAT_RATE    = 6,
   parameter int          FIFO_DEPTH     = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_BTN-1:0] btn_in_i,
   input  logic               present_i,
   input  logic               frame_tick_i,
   output logic [NUM_BTN-1:0] btn_held_o,
   output logic               evt_merged_o,
   gamepad_event_gen_if.master evt_if
);
   localparam int DB_W   = $clog2(DEBOUNCE_TICKS + 1);
   localparam int HOLD_W = $clog2(REPEAT_DELAY + 1);
   localparam int RATE_W = $clog2(REPEAT_RATE + 1);
   localparam int IDX_W  = $clog2(NUM_BTN);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;

   logic [NUM_BTN-1:0] stable_vec;
   logic [NUM_BTN-1:0] press_ev;
   logic [NUM_BTN-1:0] rep_ev;

   // ---------------- per-button debounce and repeat timing ----------------
   for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      logic [DB_W-1:0] agree_q, agree_d;
      logic            stable_q, stable_d;
      logic            press_l;

      always_comb begin
         agree_d  = agree_q;
         stable_d = stable_q;
         press_l  = 1'b0;
         if (!present_i) begin
            agree_d  = '0;
            stable_d = 1'b0;
         end else if (frame_tick_i) begin
            if (btn_in_i[gi] != stable_q) begin
               // Counter reaching DEBOUNCE_TICKS means this sample is the last agreeing one.
               if (agree_q == DB_W'(DEBOUNCE_TICKS - 1)) begin
                  stable_d = btn_in_i[gi];
                  agree_d  = '0;
                  press_l  = btn_in_i[gi];
               end else begin
                  agree_d = agree_q + 1'b1;
               end
            end else begin
               agree_d = '0;
            end
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            agree_q  <= '0;
            stable_q <= 1'b0;
         end else begin
            agree_q  <= agree_d;
            stable_q <= stable_d;
         end
      end

      assign stable_vec[gi] = stable_q;
      assign press_ev[gi]   = press_l;

      if (REPEAT_MASK[gi]) begin : g_rep
         // hold_q saturates at REPEAT_DELAY; rate_q then paces the periodic repeats,
         // so neither counter ever wraps while the button stays held.
         logic [HOLD_W-1:0] hold_q, hold_d;
         logic [RATE_W-1:0] rate_q, rate_d;
         logic              rep_l;

         always_comb begin
            hold_d = hold_q;
            rate_d = rate_q;
            rep_l  = 1'b0;
            if (!present_i || press_l || (stable_q && !stable_d)) begin
               hold_d = '0;
               rate_d = '0;
            end else if (frame_tick_i && stable_q) begin
               if (hold_q != HOLD_W'(REPEAT_DELAY)) begin
                  hold_d = hold_q + 1'b1;
                  rep_l  = (hold_q == HOLD_W'(REPEAT_DELAY - 1));
               end else if (rate_q == RATE_W'(REPEAT_RATE - 1)) begin
                  rate_d = '0;
                  rep_l  = 1'b1;
               end else begin
                  rate_d = rate_q + 1'b1;
               end
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               hold_q <= '0;
               rate_q <= '0;
            end else begin
               hold_q <= hold_d;
               rate_q <= rate_d;
            end
         end

         assign rep_ev[gi] = rep_l;
      end else begin : g_norep
         assign rep_ev[gi] = 1'b0;
      end
   end

   assign btn_held_o = stable_vec;

   // ---------------- pending set and arbiter ----------------
   logic [NUM_BTN-1:0] pend_q, pend_d;
   logic [NUM_BTN-1:0] kind_q, kind_d;   // 1 = repeat
   logic               merged_q, merged_d;
   logic               sel_valid;
   logic [IDX_W-1:0]   sel_idx;

   logic [CNT_W-1:0]   count_q, count_d;
   logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
   logic [4:0]         mem_q [FIFO_DEPTH];
   logic [4:0]         head;
   logic               fifo_empty, fifo_full, push, pop;

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
   assign pop        = !fifo_empty && evt_if.evt_ready;
   // Pending is about to be discarded when the pad is absent, so nothing is pushed then.
   assign push       = sel_valid && present_i && (!fifo_full || pop);

   always_comb begin
      sel_valid = 1'b0;
      sel_idx   = '0;
      for (int i = NUM_BTN - 1; i >= 0; i--) begin
         if (pend_q[i]) begin
            sel_valid = 1'b1;
            sel_idx   = IDX_W'(i);
         end
      end
   end

   always_comb begin
      pend_d   = pend_q;
      kind_d   = kind_q;
      merged_d = merged_q;
      if (!present_i) begin
         pend_d = '0;
         kind_d = '0;
      end else begin
         if (push) pend_d[sel_idx] = 1'b0;
         // A bit pushed this cycle is already free, so a new event there is not a merge.
         for (int i = 0; i < NUM_BTN; i++) begin
            if (press_ev[i] || rep_ev[i]) begin
               if (pend_d[i]) begin
                  merged_d = 1'b1;
                  if (press_ev[i]) kind_d[i] = 1'b0;
               end else begin
                  pend_d[i] = 1'b1;
                  kind_d[i] = rep_ev[i] && !press_ev[i];
               end
            end
         end
      end
   end

   // ---------------- event FIFO ----------------
   assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q   <= '0;
         kind_q   <= '0;
         merged_q <= 1'b0;
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         pend_q   <= pend_d;
         kind_q   <= kind_d;
         merged_q <= merged_d;
         count_q  <= count_d;
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   // Storage needs no reset: the head is masked whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {kind_q[sel_idx], 4'(sel_idx)};
   end

   assign head              = mem_q[rd_ptr_q];
   assign evt_if.evt_valid  = !fifo_empty;
   assign evt_if.evt_code   = fifo_empty ? 4'd0 : head[3:0];
   assign evt_if.evt_repeat = fifo_empty ? 1'b0 : head[4];
   assign evt_merged_o      = merged_q;
endmodule

// File: tb/tb_gamepad_event_gen.sv
module tb_gamepad_event_gen;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [11:0] btn = '0;
   logic        present = 1'b1;
   logic        frame_tick = 1'b0;
   logic [11:0] btn_held;
   logic        merged;
   int          tests = 0;
   int          fails = 0;
   logic [3:0]  evq_code[$];
   logic        evq_rep[$];

   gamepad_event_gen_if ifc ();

   gamepad_event_gen dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .btn_in_i     (btn),
      .present_i    (present),
      .frame_tick_i (frame_tick),
      .btn_held_o   (btn_held),
      .evt_merged_o (merged),
      .evt_if       (ifc)
   );

   always #5 clk = ~clk;

   // Inputs change just after posedge, so a negedge sample of valid&ready is the upcoming pop.
   always @(negedge clk) begin
      if (rst_n && ifc.evt_valid && ifc.evt_ready) begin
         evq_code.push_back(ifc.evt_code);
         evq_rep.push_back(ifc.evt_repeat);
         $display("[TB] event code=%0d repeat=%0b t=%0t", ifc.evt_code, ifc.evt_repeat, $time);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc_n(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic tick();
      frame_tick = 1'b1;
      @(posedge clk);
      #1;
      frame_tick = 1'b0;
   endtask

   task automatic tick_gap();
      tick();
      cyc_n(1);
   endtask

   // Compares captured events against packed expectations (first event most significant).
   task automatic chk_q(input string tag, input int n, input logic [31:0] exp_codes,
                        input logic [7:0] exp_reps);
      logic [31:0] oc;
      logic [7:0]  orp;
      oc  = '0;
      orp = '0;
      chk({tag, " count"}, evq_code.size(), n);
      for (int i = 0; i < evq_code.size() && i < 8; i++) begin
         oc  = (oc << 4) | 32'(evq_code[i]);
         orp = (orp << 1) | 8'(evq_rep[i]);
      end
      chk({tag, " codes"}, oc, exp_codes);
      chk({tag, " kinds"}, 32'(orp), 32'(exp_reps));
      evq_code.delete();
      evq_rep.delete();
   endtask

   initial begin
      ifc.evt_ready = 1'b1;
      cyc_n(3);
      rst_n = 1'b1;
      cyc_n(2);
      chk("reset valid", 32'(ifc.evt_valid), 0);
      chk("reset code", 32'(ifc.evt_code), 0);
      chk("reset repeat", 32'(ifc.evt_repeat), 0);
      chk("reset held", 32'(btn_held), 0);
      chk("reset merged", 32'(merged), 0);

      // 1: single press of a, latency of two cycles after the second tick
      btn[3] = 1'b1;
      tick_gap();
      tick();
      chk("t1 valid T+1", 32'(ifc.evt_valid), 0);
      chk("t1 held", 32'(btn_held), 32'h008);
      cyc_n(1);
      chk("t1 valid T+2", 32'(ifc.evt_valid), 1);
      chk("t1 code", 32'(ifc.evt_code), 3);
      chk("t1 repeat", 32'(ifc.evt_repeat), 0);
      tick_gap();
      btn[3] = 1'b0;
      tick_gap();
      tick_gap();
      cyc_n(3);
      chk("t1 held after release", 32'(btn_held), 0);
      chk_q("t1 events", 1, 32'h3, 8'h0);

      // 2: one-tick glitch is rejected
      btn[5] = 1'b1;
      tick_gap();
      btn[5] = 1'b0;
      tick_gap();
      tick_gap();
      cyc_n(3);
      chk("t2 held", 32'(btn_held), 0);
      chk_q("t2 events", 0, 32'h0, 8'h0);

      // 3: right held 40 ticks -> press plus repeats at hold 20,26,32,38
      btn[4] = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         tick_gap();
         if (i == 21) begin
            cyc_n(1);
            chk("t3 events after tick 21", evq_code.size(), 1);
         end
         if (i == 22) begin
            cyc_n(1);
            chk("t3 events after tick 22", evq_code.size(), 2);
         end
      end
      btn[4] = 1'b0;
      tick_gap();
      tick_gap();
      cyc_n(3);
      chk_q("t3 events", 5, 32'h44444, 8'b01111);

      // 4: FIFO fills with 0,1,2,8; 9 and 10 wait in pending
      ifc.evt_ready = 1'b0;
      btn = 12'h707;
      tick_gap();
      tick();
      cyc_n(8);
      chk("t4 valid full", 32'(ifc.evt_valid), 1);
      chk("t4 head", 32'(ifc.evt_code), 0);
      chk("t4 no pops", evq_code.size(), 0);
      ifc.evt_ready = 1'b1;
      cyc_n(12);
      chk_q("t4 events", 6, 32'h01289A, 8'h0);
      chk("t4 merged", 32'(merged), 0);
      btn = '0;
      tick_gap();
      tick_gap();
      cyc_n(2);

      // 4b: re-press of a still-pending button merges into one event
      ifc.evt_ready = 1'b0;
      btn = 12'h307;
      tick_gap();
      tick_gap();
      cyc_n(6);
      btn = '0;
      tick_gap();
      tick_gap();
      btn = 12'h200;
      tick_gap();
      tick_gap();
      chk("t4b merged", 32'(merged), 1);
      ifc.evt_ready = 1'b1;
      cyc_n(10);
      chk_q("t4b events", 5, 32'h01289, 8'h0);
      btn = '0;
      tick_gap();
      tick_gap();
      cyc_n(2);

      // 5: pad removed while up is held with one event queued
      ifc.evt_ready = 1'b0;
      btn[7] = 1'b1;
      tick_gap();
      tick_gap();
      for (int i = 0; i < 5; i++) tick_gap();
      chk("t5 queued code", 32'(ifc.evt_code), 7);
      present = 1'b0;
      cyc_n(1);
      chk("t5 held cleared", 32'(btn_held), 0);
      for (int i = 0; i < 25; i++) tick_gap();
      chk("t5 still queued", 32'(ifc.evt_valid), 1);
      chk("t5 held absent", 32'(btn_held), 0);
      ifc.evt_ready = 1'b1;
      cyc_n(4);
      chk_q("t5 events", 1, 32'h7, 8'h0);
      btn = '0;
      present = 1'b1;
      cyc_n(3);
      chk("t5 drained", 32'(ifc.evt_valid), 0);

      // 6: asynchronous reset in the middle of a drain
      ifc.evt_ready = 1'b0;
      btn = 12'h007;
      tick_gap();
      tick_gap();
      cyc_n(5);
      ifc.evt_ready = 1'b1;
      cyc_n(1);
      chk("t6 mid drain valid", 32'(ifc.evt_valid), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6 async valid", 32'(ifc.evt_valid), 0);
      chk("t6 async code", 32'(ifc.evt_code), 0);
      chk("t6 async held", 32'(btn_held), 0);
      chk("t6 async merged", 32'(merged), 0);
      btn = '0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      evq_code.delete();
      evq_rep.delete();
      cyc_n(4);
      chk("t6 post valid", 32'(ifc.evt_valid), 0);
      chk("t6 post held", 32'(btn_held), 0);
      chk("t6 post events", evq_code.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
